huffman_hist_sort: RTL
======================

Name: huffman_hist_sort

Overview:
- Parametrised successor to the fixed 6-symbol gray-level counter: it histograms a gray_data stream over NUM_SYM symbols.
- After the stream ends, it publishes the counts and sorts the symbols by ascending count, ready for Huffman tree merging.
- It sits between the pixel source and the code-generation stage.
- New versus the previous generation:
  - symbol count and counter width are parameters;
  - counters saturate;
  - error flags;
  - a built-in sequential sort;
  - frame restart without reset.

Parameters:
- NUM_SYM, 6, number of symbols; valid symbol values 1..NUM_SYM; range 2..16.
- DATA_W, 8, gray_data width.
- CNT_W, 8, per-symbol counter width.
- IDX_W, 4, width of a symbol index; must satisfy 2^IDX_W > NUM_SYM.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- gray_valid  in  1  sample strobe; frame = maximal run of consecutive high cycles.
- gray_data  in  DATA_W  symbol value.
- CNT_valid  out  1  one-cycle pulse; cnt_flat is final.
- cnt_flat  out  NUM_SYM*CNT_W  counter k (symbol k+1) at bits [k*CNT_W +: CNT_W].
- sort_valid  out  1  one-cycle pulse; sorted outputs are final.
- sort_idx_flat  out  NUM_SYM*IDX_W  rank r holds the symbol value (1..NUM_SYM), rank 0 = smallest count.
- sort_cnt_flat  out  NUM_SYM*CNT_W  count belonging to rank r.
- busy  out  1  high in CNT_OUT, SORT and SORT_OUT.
- err  out  3  sticky: [0] out-of-range symbol, [1] counter saturated, [2] sample dropped while busy.

Behaviour:
- Reset (synchronous, priority over everything):
  - state = IDLE;
  - all counters, sort registers, sort_idx_flat, sort_cnt_flat and err = 0;
  - CNT_valid, sort_valid, busy = 0.
- States: IDLE, REC, CNT_OUT, SORT, SORT_OUT, DONE.
- IDLE:
  - gray_valid = 1: count the sample, go to REC.
  - Otherwise stay in IDLE.
- REC:
  - gray_valid = 1: count the sample, stay in REC.
  - gray_valid = 0: go to CNT_OUT. Counts are final on this edge.
- CNT_OUT (1 cycle):
  - CNT_valid = 1;
  - load sort registers from the counters, entry k = (cnt k, symbol k+1);
  - clear the pass counter;
  - go to SORT.
- SORT (exactly NUM_SYM cycles):
  - odd-even transposition sort, one pass per cycle;
  - pass p compares pairs (i, i+1) with i even when p is even, i odd when p is odd;
  - exchange when the pair is out of order under key (count, symbol): lower count first, ties broken by lower symbol value first;
  - after pass NUM_SYM-1, go to SORT_OUT.
- SORT_OUT (1 cycle):
  - sort_valid = 1;
  - sort_idx_flat and sort_cnt_flat are registered on entry to SORT_OUT and hold until the next reset or restart;
  - go to DONE.
- DONE:
  - gray_valid = 0: stay in DONE; counts and sorted outputs hold.
  - gray_valid = 1 (restart): all counters are set to 0 except the symbol of this sample, which is set to 1 if in range. Go to REC. err is NOT cleared.
- Counting:
  - only in IDLE, REC and the DONE restart cycle;
  - gray_data in 1..NUM_SYM increments counter gray_data-1;
  - any other value (0 or > NUM_SYM) is not counted and sets err[0];
  - a counter at 2^CNT_W-1 holds and sets err[1].
- Samples while busy: gray_valid = 1 in CNT_OUT, SORT or SORT_OUT is ignored (no count, no state change) and sets err[2].
- Latency:
  - first gray_valid = 0 cycle at cycle t;
  - CNT_valid high in cycle t+1;
  - SORT occupies cycles t+2 .. t+1+NUM_SYM;
  - sort_valid high in cycle t+2+NUM_SYM.
- cnt_flat mirrors the live counters in every state.

Decomposition:
- Package huffman_pkg:
  - state enum / localparams (IDLE=0, REC=1, CNT_OUT=2, SORT=3, SORT_OUT=4, DONE=5);
  - err bit-position constants;
  - helper function computing the index key compare.
- Sub-module huffman_sort_stage:
  - combinational single compare-exchange of two (count, idx) entries;
  - instantiated NUM_SYM-1 times via generate;
  - the parent selects odd or even pairs per pass.

Test Plan:
- Basic (NUM_SYM=6, CNT_W=8)
  - Stimulus: stream 1,1,2,3,3,3,4,5,5,6 in cycles 0..9.
  - Response: CNT_valid in cycle 11, cnt = 2,1,3,1,2,1; sort_valid in cycle 18; sort_idx = 2,4,6,1,5,3; sort_cnt = 1,1,1,2,2,3; err = 0.
- Saturation (CNT_W=4)
  - Stimulus: 20 samples of 2.
  - Response: CNT2 = 15; err[1] = 1; sorted order 1,3,4,5,6,2 with counts 0,0,0,0,0,15.
- Illegal symbols
  - Stimulus: stream 0,7,255,4.
  - Response: only cnt4 = 1; err[0] = 1; sort_idx = 1,2,3,5,6,4.
- Busy drop / restart
  - Stimulus: gray_valid pulsed during SORT, then a new frame 5,5 while in DONE.
  - Response: the SORT pulse is not counted and sets err[2]; the restart gives cnt5 = 2, all others 0; a second sort_valid follows; err stays set.
- Reset mid-SORT
  - Stimulus: reset asserted on the third SORT cycle.
  - Response: next cycle state = IDLE, all outputs 0, no sort_valid; a following frame sorts correctly.
- Parameter sweep
  - Stimulus: NUM_SYM = 2, 6 and 16 with random streams.
  - Response: sorted outputs match a reference model; a pass is ascending order with ties by lower symbol.

Source files
------------

// File: rtl/huffman_pkg.sv
// Shared types and helpers for the histogram / sort block.
package huffman_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REC      = 3'd1,
    CNT_OUT  = 3'd2,
    SORT     = 3'd3,
    SORT_OUT = 3'd4,
    DONE     = 3'd5
  } state_t;

  localparam int unsigned ERR_W     = 3;
  localparam int unsigned ERR_RANGE = 0;  // symbol outside 1..NUM_SYM
  localparam int unsigned ERR_SAT   = 1;  // a counter hit its maximum
  localparam int unsigned ERR_DROP  = 2;  // sample arrived while busy

  // Width used for key comparisons; callers zero-extend into it.
  localparam int unsigned KEY_W = 32;

  // True when entry a must follow entry b: larger count, or equal count and larger symbol.
  function automatic logic key_gt(input logic [KEY_W-1:0] cnt_a,
                                  input logic [KEY_W-1:0] idx_a,
                                  input logic [KEY_W-1:0] cnt_b,
                                  input logic [KEY_W-1:0] idx_b);
    return (cnt_a > cnt_b) || ((cnt_a == cnt_b) && (idx_a > idx_b));
  endfunction

endpackage

// File: rtl/huffman_sort_stage.sv
// Single combinational compare-exchange of two (count, symbol) entries.
module huffman_sort_stage
  import huffman_pkg::*;
#(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned IDX_W = 4
) (
  input  logic [CNT_W-1:0] a_cnt,
  input  logic [IDX_W-1:0] a_idx,
  input  logic [CNT_W-1:0] b_cnt,
  input  logic [IDX_W-1:0] b_idx,
  output logic [CNT_W-1:0] lo_cnt_c,
  output logic [IDX_W-1:0] lo_idx_c,
  output logic [CNT_W-1:0] hi_cnt_c,
  output logic [IDX_W-1:0] hi_idx_c
);

  logic swap_c;

  // Route the smaller key to the lower position.
  always_comb begin
    swap_c   = key_gt(KEY_W'(a_cnt), KEY_W'(a_idx), KEY_W'(b_cnt), KEY_W'(b_idx));
    lo_cnt_c = a_cnt;
    lo_idx_c = a_idx;
    hi_cnt_c = b_cnt;
    hi_idx_c = b_idx;
    if (swap_c) begin
      lo_cnt_c = b_cnt;
      lo_idx_c = b_idx;
      hi_cnt_c = a_cnt;
      hi_idx_c = a_idx;
    end
  end

endmodule

// File: rtl/huffman_hist_sort.sv
// Symbol histogram over a gray_data frame followed by an odd-even transposition
// sort of (count, symbol) pairs, ready for Huffman tree merging.
module huffman_hist_sort
  import huffman_pkg::*;
#(
  parameter int unsigned NUM_SYM = 6,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned IDX_W   = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       gray_valid,
  input  logic [DATA_W-1:0]          gray_data,
  output logic                       CNT_valid,
  output logic [NUM_SYM*CNT_W-1:0]   cnt_flat,
  output logic                       sort_valid,
  output logic [NUM_SYM*IDX_W-1:0]   sort_idx_flat,
  output logic [NUM_SYM*CNT_W-1:0]   sort_cnt_flat,
  output logic                       busy,
  output logic [ERR_W-1:0]           err
);

  localparam int unsigned PASS_W    = (NUM_SYM > 2) ? $clog2(NUM_SYM) : 1;
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(NUM_SYM - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  state_t state_q, state_d;

  logic [CNT_W-1:0]  cnt_q     [NUM_SYM];
  logic [CNT_W-1:0]  srt_cnt_q [NUM_SYM];
  logic [IDX_W-1:0]  srt_idx_q [NUM_SYM];
  logic [CNT_W-1:0]  srt_cnt_d [NUM_SYM];
  logic [IDX_W-1:0]  srt_idx_d [NUM_SYM];
  logic [PASS_W-1:0] pass_q;

  logic [CNT_W-1:0]  st_lo_cnt [NUM_SYM-1];
  logic [IDX_W-1:0]  st_lo_idx [NUM_SYM-1];
  logic [CNT_W-1:0]  st_hi_cnt [NUM_SYM-1];
  logic [IDX_W-1:0]  st_hi_idx [NUM_SYM-1];

  logic               count_en_c, restart_c, load_c, step_c, publish_c, drop_c;
  logic [NUM_SYM-1:0] hit_c;
  logic               in_range_c, sat_c;
  logic [ERR_W-1:0]   err_set_c;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and per-cycle datapath controls.
  always_comb begin
    state_d    = state_q;
    count_en_c = 1'b0;
    restart_c  = 1'b0;
    load_c     = 1'b0;
    step_c     = 1'b0;
    publish_c  = 1'b0;
    drop_c     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gray_valid) begin
          count_en_c = 1'b1;
          state_d    = REC;
        end
      end
      REC: begin
        if (gray_valid) count_en_c = 1'b1;
        else            state_d    = CNT_OUT;
      end
      CNT_OUT: begin
        load_c  = 1'b1;
        drop_c  = gray_valid;
        state_d = SORT;
      end
      SORT: begin
        step_c = 1'b1;
        drop_c = gray_valid;
        if (pass_q == LAST_PASS) begin
          publish_c = 1'b1;
          state_d   = SORT_OUT;
        end
      end
      SORT_OUT: begin
        drop_c  = gray_valid;
        state_d = DONE;
      end
      DONE: begin
        if (gray_valid) begin
          restart_c = 1'b1;
          state_d   = REC;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Decode the incoming symbol against the counter bank.
  always_comb begin
    hit_c      = '0;
    in_range_c = 1'b0;
    sat_c      = 1'b0;
    for (int k = 0; k < int'(NUM_SYM); k++) begin
      if (32'(gray_data) == (32'(k) + 32'd1)) begin
        hit_c[k]   = 1'b1;
        in_range_c = 1'b1;
        if (cnt_q[k] == CNT_MAX) sat_c = 1'b1;
      end
    end
    err_set_c            = '0;
    err_set_c[ERR_RANGE] = (count_en_c || restart_c) && !in_range_c;
    err_set_c[ERR_SAT]   = count_en_c && sat_c;
    err_set_c[ERR_DROP]  = drop_c;
  end

  // Saturating per-symbol counters; a restart reseeds them from the first sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < int'(NUM_SYM); k++) cnt_q[k] <= '0;
    end else if (restart_c) begin
      for (int k = 0; k < int'(NUM_SYM); k++) cnt_q[k] <= hit_c[k] ? CNT_W'(1) : '0;
    end else if (count_en_c) begin
      for (int k = 0; k < int'(NUM_SYM); k++) begin
        if (hit_c[k] && (cnt_q[k] != CNT_MAX)) cnt_q[k] <= cnt_q[k] + CNT_W'(1);
      end
    end
  end

  // Compare-exchange elements between every adjacent pair.
  for (genvar i = 0; i < int'(NUM_SYM) - 1; i++) begin : g_stage
    huffman_sort_stage #(
      .CNT_W (CNT_W),
      .IDX_W (IDX_W)
    ) u_stage (
      .a_cnt    (srt_cnt_q[i]),
      .a_idx    (srt_idx_q[i]),
      .b_cnt    (srt_cnt_q[i+1]),
      .b_idx    (srt_idx_q[i+1]),
      .lo_cnt_c (st_lo_cnt[i]),
      .lo_idx_c (st_lo_idx[i]),
      .hi_cnt_c (st_hi_cnt[i]),
      .hi_idx_c (st_hi_idx[i])
    );
  end

  // Apply only the pairs whose left index parity matches the pass parity.
  always_comb begin
    for (int k = 0; k < int'(NUM_SYM); k++) begin
      srt_cnt_d[k] = srt_cnt_q[k];
      srt_idx_d[k] = srt_idx_q[k];
    end
    for (int i = 0; i < int'(NUM_SYM) - 1; i++) begin
      if (1'(i) == pass_q[0]) begin
        srt_cnt_d[i]   = st_lo_cnt[i];
        srt_idx_d[i]   = st_lo_idx[i];
        srt_cnt_d[i+1] = st_hi_cnt[i];
        srt_idx_d[i+1] = st_hi_idx[i];
      end
    end
  end

  // Sort working registers and pass counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < int'(NUM_SYM); k++) begin
        srt_cnt_q[k] <= '0;
        srt_idx_q[k] <= '0;
      end
      pass_q <= '0;
    end else if (load_c) begin
      for (int k = 0; k < int'(NUM_SYM); k++) begin
        srt_cnt_q[k] <= cnt_q[k];
        srt_idx_q[k] <= IDX_W'(k + 1);
      end
      pass_q <= '0;
    end else if (step_c) begin
      for (int k = 0; k < int'(NUM_SYM); k++) begin
        srt_cnt_q[k] <= srt_cnt_d[k];
        srt_idx_q[k] <= srt_idx_d[k];
      end
      pass_q <= pass_q + PASS_W'(1);
    end
  end

  // Registered status, strobes, sticky errors and published sort result.
  always_ff @(posedge clk) begin
    if (reset) begin
      CNT_valid     <= 1'b0;
      sort_valid    <= 1'b0;
      busy          <= 1'b0;
      err           <= '0;
      sort_idx_flat <= '0;
      sort_cnt_flat <= '0;
    end else begin
      CNT_valid  <= (state_d == CNT_OUT);
      sort_valid <= (state_d == SORT_OUT);
      busy       <= (state_d == CNT_OUT) || (state_d == SORT) || (state_d == SORT_OUT);
      err        <= err | err_set_c;
      if (publish_c) begin
        for (int k = 0; k < int'(NUM_SYM); k++) begin
          sort_idx_flat[k*IDX_W +: IDX_W] <= srt_idx_d[k];
          sort_cnt_flat[k*CNT_W +: CNT_W] <= srt_cnt_d[k];
        end
      end
    end
  end

  // Live counter view.
  always_comb begin
    for (int k = 0; k < int'(NUM_SYM); k++) cnt_flat[k*CNT_W +: CNT_W] = cnt_q[k];
  end

endmodule
